// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP sliding-window scheduler.
package lbp_pkg;

   localparam int IMG_DIM_DEFAULT = 128;
   localparam int AW_DEFAULT      = 14;

   // Border constants: centre pixels run FIRST..LAST on both axes.
   localparam int FIRST = 1;
   localparam int LAST  = IMG_DIM_DEFAULT - 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRIME   = 3'd1,
      FETCH   = 3'd2,
      COMPUTE = 3'd3,
      WRITE   = 3'd4,
      FINISH  = 3'd5
   } state_t;

endpackage

// File: rtl/lbp_window_sched_if.sv
// Bundle between the scheduler, the gray-image memory port and the LBP datapath.
//
// Handshake semantics: gray_ready is a level qualifier sampled only while the
// scheduler is idle. gray_req, row_wr, col_shift, compute_en and lbp_valid are
// single-cycle strobes with no back-pressure; gray_data is valid in the same
// cycle as gray_req, and lbp_addr is the write address whenever lbp_valid=1.
interface lbp_window_sched_if
   import lbp_pkg::*;
#(
   parameter int AW = AW_DEFAULT
);
   logic          gray_ready;
   logic [AW-1:0] gray_addr;
   logic          gray_req;
   logic          col_shift;
   logic [2:0]    row_wr;
   logic          compute_en;
   logic [AW-1:0] lbp_addr;
   logic          lbp_valid;
   logic          finish;

   modport master (
      input  gray_ready,
      output gray_addr, gray_req, col_shift, row_wr,
      output compute_en, lbp_addr, lbp_valid, finish
   );

   modport slave (
      output gray_ready,
      input  gray_addr, gray_req, col_shift, row_wr,
      input  compute_en, lbp_addr, lbp_valid, finish
   );
endinterface

// File: rtl/lbp_pos_cnt.sv
// Centre-pixel position counter: walks x across a row, wraps to the next row,
// and flags the last column and the last pixel of the frame.
module lbp_pos_cnt
   import lbp_pkg::*;
#(
   parameter int IMG_DIM = IMG_DIM_DEFAULT,
   parameter int PW      = $clog2(IMG_DIM)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          adv,
   output logic [PW-1:0] x,
   output logic [PW-1:0] y,
   output logic          last_col,
   output logic          last_pix
);
   localparam logic [PW-1:0] FIRST_P = PW'(FIRST);
   localparam logic [PW-1:0] LAST_P  = PW'(IMG_DIM - 2);

   assign last_col = (x == LAST_P);
   assign last_pix = last_col && (y == LAST_P);

   // Advance one centre pixel per completed write; hold at the final pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x <= FIRST_P;
         y <= FIRST_P;
      end else if (adv && !last_pix) begin
         if (last_col) begin
            x <= FIRST_P;
            y <= y + PW'(1);
         end else begin
            x <= x + PW'(1);
         end
      end
   end
endmodule

// File: rtl/lbp_window_sched.sv
// Sliding 3x3 window scheduler: primes 9 reads at each row start, then fetches
// only the new right-hand column per pixel, and sequences compute/write.
module lbp_window_sched
   import lbp_pkg::*;
#(
   parameter int IMG_DIM = IMG_DIM_DEFAULT,
   parameter int AW      = AW_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   lbp_window_sched_if.master  bus,
   output state_t              state
);
   localparam int PW = AW / 2;

   logic [1:0]    rcnt;
   logic [1:0]    ccnt;
   logic [PW-1:0] x;
   logic [PW-1:0] y;
   logic          last_col;
   logic          last_pix;

   logic          rd;
   logic [PW-1:0] row_sel;
   logic [PW-1:0] col_sel;
   logic [AW-1:0] gray_addr;
   logic [2:0]    row_wr;

   lbp_pos_cnt #(
      .IMG_DIM (IMG_DIM),
      .PW      (PW)
   ) u_pos (
      .clk      (clk),
      .reset    (reset),
      .adv      (state == WRITE),
      .x        (x),
      .y        (y),
      .last_col (last_col),
      .last_pix (last_pix)
   );

   // Control FSM with window row/column counters; PRIME walks column-major.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         rcnt  <= 2'd0;
         ccnt  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               rcnt <= 2'd0;
               ccnt <= 2'd0;
               if (bus.gray_ready) state <= PRIME;
            end
            PRIME: begin
               if (rcnt == 2'd2) begin
                  rcnt <= 2'd0;
                  if (ccnt == 2'd2) begin
                     ccnt  <= 2'd0;
                     state <= COMPUTE;
                  end else begin
                     ccnt <= ccnt + 2'd1;
                  end
               end else begin
                  rcnt <= rcnt + 2'd1;
               end
            end
            FETCH: begin
               if (rcnt == 2'd2) begin
                  rcnt  <= 2'd0;
                  state <= COMPUTE;
               end else begin
                  rcnt <= rcnt + 2'd1;
               end
            end
            COMPUTE: state <= WRITE;
            WRITE: begin
               if (last_pix)      state <= FINISH;
               else if (last_col) state <= PRIME;
               else               state <= FETCH;
            end
            FINISH:  state <= FINISH;
            default: state <= IDLE;
         endcase
      end
   end

   // Read address and window strobes decoded from registered state only.
   always_comb begin
      rd      = (state == PRIME) || (state == FETCH);
      row_sel = y + PW'(rcnt) - PW'(1);
      col_sel = (state == PRIME) ? (x + PW'(ccnt) - PW'(1)) : (x + PW'(1));
      gray_addr = '0;
      row_wr    = 3'b000;
      if (rd) begin
         gray_addr = {row_sel, col_sel};
         row_wr    = 3'b001 << rcnt;
      end
   end

   assign bus.gray_req   = rd;
   assign bus.gray_addr  = gray_addr;
   assign bus.row_wr     = row_wr;
   assign bus.col_shift  = rd && (rcnt == 2'd0);
   assign bus.compute_en = (state == COMPUTE);
   assign bus.lbp_valid  = (state == WRITE);
   assign bus.lbp_addr   = {y, x};
   assign bus.finish     = (state == FINISH);
endmodule

// File: tb/tb_lbp_window_sched.sv
// Bench for lbp_window_sched: a frame model fills expected read/write queues
// when a start is issued, and a negedge monitor pops and compares.
module tb_lbp_window_sched;
   import lbp_pkg::*;

   localparam int DIM   = 128;
   localparam int AW    = 14;
   localparam int LASTP = DIM - 2;
   localparam int NPIX  = LASTP * LASTP;

   // ---------------- clock / reset ----------------
   logic   clk   = 1'b0;
   logic   reset = 1'b0;
   int     cyc   = 0;
   state_t state;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lbp_window_sched_if #(.AW(AW)) bus ();

   lbp_window_sched #(
      .IMG_DIM (DIM),
      .AW      (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .state (state)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [2:0]    row_wr;
      logic          col_shift;
   } rd_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
   } wr_t;

   rd_t rq[$];
   wr_t wq[$];
   int  n_checks    = 0;
   int  n_errors    = 0;
   int  nwrites     = 0;
   int  exp_finish  = -1;
   bit  mon_en      = 1'b0;
   bit  finish_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] mk_addr(input int r, input int c);
      return AW'(r * DIM + c);
   endfunction

   // Expected frame: row start reads 3 columns x 3 rows, later pixels read one
   // column; each pixel then spends one compute cycle and one write cycle.
   task automatic push_frame(input int start, input int npix);
      int t = start;
      int n = 0;
      rd_t e;
      wr_t w;
      exp_finish = -1;
      for (int yy = 1; yy <= LASTP; yy++) begin
         for (int xx = 1; xx <= LASTP; xx++) begin
            if (n == npix) return;
            if (xx == 1) begin
               for (int cc = 0; cc < 3; cc++) begin
                  for (int r = 0; r < 3; r++) begin
                     e.cyc = t; e.addr = mk_addr(yy - 1 + r, cc);
                     e.row_wr = 3'(1 << r); e.col_shift = (r == 0);
                     rq.push_back(e);
                     t++;
                  end
               end
            end else begin
               for (int r = 0; r < 3; r++) begin
                  e.cyc = t; e.addr = mk_addr(yy - 1 + r, xx + 1);
                  e.row_wr = 3'(1 << r); e.col_shift = (r == 0);
                  rq.push_back(e);
                  t++;
               end
            end
            t++;  // compute cycle
            w.cyc = t; w.addr = mk_addr(yy, xx);
            wq.push_back(w);
            t++;
            n++;
         end
      end
      exp_finish = t;
   endtask

   // Output monitor: compares every strobe against the queues.
   always @(negedge clk) begin
      rd_t e;
      wr_t w;
      if (mon_en) begin
         if (bus.gray_req) begin
            check("read_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
               e = rq.pop_front();
               check("read_cyc", cyc, e.cyc);
               check("read_addr", 32'(bus.gray_addr), 32'(e.addr));
               check("row_wr", 32'(bus.row_wr), 32'(e.row_wr));
               check("col_shift", 32'(bus.col_shift), 32'(e.col_shift));
            end
         end else begin
            check("idle_rd_strobes", {bus.gray_addr, bus.row_wr, bus.col_shift}, 32'd0);
         end
         if (bus.compute_en) begin
            check("compute_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) check("compute_cyc", cyc + 1, wq[0].cyc);
         end
         if (bus.lbp_valid) begin
            nwrites++;
            check("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               w = wq.pop_front();
               check("write_cyc", cyc, w.cyc);
               check("lbp_addr", 32'(bus.lbp_addr), 32'(w.addr));
            end
         end
         if (bus.finish && !finish_seen) begin
            finish_seen = 1'b1;
            check("finish_cyc", cyc, exp_finish);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_gray_req"},   32'(bus.gray_req),   32'd0);
      check({pfx, "_gray_addr"},  32'(bus.gray_addr),  32'd0);
      check({pfx, "_row_wr"},     32'(bus.row_wr),     32'd0);
      check({pfx, "_col_shift"},  32'(bus.col_shift),  32'd0);
      check({pfx, "_compute_en"}, 32'(bus.compute_en), 32'd0);
      check({pfx, "_lbp_valid"},  32'(bus.lbp_valid),  32'd0);
      check({pfx, "_finish"},     32'(bus.finish),     32'd0);
      check({pfx, "_lbp_addr"},   32'(bus.lbp_addr),   32'h0081);
      check({pfx, "_state"},      32'(state),          32'(IDLE));
   endtask

   // Pulse gray_ready for one cycle, queue the expected frame and start checking.
   task automatic start_frame(input int npix, output int start);
      rq.delete();
      wq.delete();
      nwrites     = 0;
      finish_seen = 1'b0;
      bus.gray_ready = 1'b1;
      start = cyc + 1;
      push_frame(start, npix);
      mon_en = 1'b1;
      step();
      bus.gray_ready = 1'b0;
   endtask

   task automatic wait_writes_done(input string tag, input int budget);
      int limit = cyc + budget;
      while (wq.size() != 0 && cyc < limit) step();
      check({tag, "_done_in_budget"}, 32'(wq.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int start;
      bus.gray_ready = 1'b1;
      reset = 1'b0;

      // Reset held with gray_ready high: nothing may start.
      repeat (3) begin
         step();
         check_reset_vals("rst");
      end

      // Full frame: first pixel, steady state, row wraps, finish timing.
      bus.gray_ready = 1'b0;
      reset = 1'b1;
      repeat (2) step();
      start_frame(NPIX, start);
      wait_writes_done("frame", LASTP * (11 + (DIM - 3) * 5) + 50);
      step();
      check("frame_writes", nwrites, NPIX);
      check("frame_reads_left", 32'(rq.size()), 32'd0);
      check("finish_seen", 32'(finish_seen), 32'd1);

      // Finish holds while gray_ready toggles.
      for (int i = 0; i < 100; i++) begin
         bus.gray_ready = 1'($urandom_range(0, 1));
         step();
         check("hold_finish", 32'(bus.finish), 32'd1);
         check("hold_no_req", 32'(bus.gray_req), 32'd0);
         check("hold_no_valid", 32'(bus.lbp_valid), 32'd0);
      end
      bus.gray_ready = 1'b0;

      // Reset out of FINISH, start again, then reset during a FETCH read.
      reset = 1'b0;
      step();
      check_reset_vals("rst_fin");
      reset = 1'b1;
      repeat (2) step();
      start_frame(5, start);
      while (cyc < start + 12) step();
      check("mid_fetch_req", 32'(bus.gray_req), 32'd1);
      check("mid_fetch_state", 32'(state), 32'(FETCH));
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      step();
      reset = 1'b1;
      repeat (3) step();

      // Restart reproduces the first pixels and a row wrap.
      start_frame(130, start);
      wait_writes_done("restart", 130 * 11 + 50);
      mon_en = 1'b0;
      check("restart_writes", nwrites, 130);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
